// File: rtl/wait_fee_acc.sv
// wait_fee_acc: decodes the toggling minute signal into single-cycle ticks,
// accumulates waiting minutes as 2-digit BCD (saturating at 99) and charges
// a waiting fee for every minute beyond a free allowance, clamped at FEE_MAX.
module wait_fee_acc #(
  parameter int unsigned FREE_MIN    = 3,
  parameter int unsigned FEE_PER_MIN = 10,
  parameter int unsigned FEE_MAX     = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clear,
  input  logic        max_in,
  input  logic        min_pulse,
  output logic        min_tick,
  output logic [7:0]  wait_min_bcd,
  output logic [11:0] wait_fee,
  output logic        fee_tick,
  output logic        sat
);

  logic        pulse_q;
  logic        edge_seen;
  logic        cnt;
  logic [3:0]  units;
  logic [3:0]  tens;
  logic [3:0]  units_n;
  logic [3:0]  tens_n;
  logic        at_max;
  logic [6:0]  next_bin;
  logic [12:0] fee_sum;
  logic [11:0] fee_clamped;
  logic        charge;
  logic [7:0]  min_nx;
  logic [11:0] fee_nx;
  logic        sat_nx;

  // Edge detect and qualified count strobe.
  always_comb begin
    edge_seen = min_pulse ^ pulse_q;
    cnt       = edge_seen & en & ~max_in & ~clear;
  end

  // BCD increment, fee charge and next-state selection by priority.
  always_comb begin
    units   = wait_min_bcd[3:0];
    tens    = wait_min_bcd[7:4];
    at_max  = (wait_min_bcd == 8'h99);
    units_n = '0;
    tens_n  = tens;
    if (units == 4'd9) begin
      units_n = '0;
      tens_n  = 4'(tens + 4'd1);
    end else begin
      units_n = 4'(units + 4'd1);
    end
    next_bin    = 7'(tens_n) * 7'd10 + 7'(units_n);
    // 13-bit sum so the carry out of 12 bits is seen before clamping.
    fee_sum     = {1'b0, wait_fee} + 13'(FEE_PER_MIN);
    fee_clamped = (fee_sum > 13'(FEE_MAX)) ? 12'(FEE_MAX) : fee_sum[11:0];
    charge      = ~at_max & (32'(next_bin) > FREE_MIN);

    min_nx = wait_min_bcd;
    fee_nx = wait_fee;
    if (clear) begin
      min_nx = '0;
      fee_nx = '0;
    end else if (cnt) begin
      if (!at_max) min_nx = {tens_n, units_n};
      if (charge)  fee_nx = fee_clamped;
    end
    sat_nx = ~clear & ((min_nx == 8'h99) | (fee_nx == 12'(FEE_MAX)));
  end

  // Registered state and outputs; tick/fee_tick are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_q      <= 1'b0;
      min_tick     <= 1'b0;
      wait_min_bcd <= '0;
      wait_fee     <= '0;
      fee_tick     <= 1'b0;
      sat          <= 1'b0;
    end else begin
      pulse_q      <= min_pulse;
      min_tick     <= edge_seen;
      wait_min_bcd <= min_nx;
      wait_fee     <= fee_nx;
      fee_tick     <= (fee_nx > wait_fee);
      sat          <= sat_nx;
    end
  end

endmodule

// File: tb/tb_wait_fee_acc.sv
// Testbench for wait_fee_acc: two instances (fee 10/min and 1000/min) share
// the same stimulus and are compared every cycle against an arithmetic model.
module tb_wait_fee_acc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic max_in = 1'b0;
  logic min_pulse = 1'b0;

  logic        tick_a, tick_b, ft_a, ft_b, sat_a, sat_b;
  logic [7:0]  bcd_a, bcd_b;
  logic [11:0] fee_a, fee_b;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_min = 0;
  int  m_fa = 0;
  int  m_fb = 0;
  bit  m_q = 1'b0;
  bit  e_tick = 1'b0;
  bit  e_fta = 1'b0;
  bit  e_ftb = 1'b0;
  bit  e_sata = 1'b0;
  bit  e_satb = 1'b0;

  always #10 clk = ~clk;

  wait_fee_acc #(.FREE_MIN(3), .FEE_PER_MIN(10), .FEE_MAX(4095)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .max_in(max_in),
    .min_pulse(min_pulse), .min_tick(tick_a), .wait_min_bcd(bcd_a),
    .wait_fee(fee_a), .fee_tick(ft_a), .sat(sat_a)
  );

  wait_fee_acc #(.FREE_MIN(3), .FEE_PER_MIN(1000), .FEE_MAX(4095)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .max_in(max_in),
    .min_pulse(min_pulse), .min_tick(tick_b), .wait_min_bcd(bcd_b),
    .wait_fee(fee_b), .fee_tick(ft_b), .sat(sat_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int charged(input int f, input int p);
    return (f + p > 4095) ? 4095 : f + p;
  endfunction

  task automatic compare_all();
    logic [7:0] e_bcd;
    e_bcd = 8'((m_min / 10) * 16 + (m_min % 10));
    check("min_tick_a", 32'(tick_a), 32'(e_tick));
    check("min_tick_b", 32'(tick_b), 32'(e_tick));
    check("bcd_a", 32'(bcd_a), 32'(e_bcd));
    check("bcd_b", 32'(bcd_b), 32'(e_bcd));
    check("fee_a", 32'(fee_a), 32'(m_fa));
    check("fee_b", 32'(fee_b), 32'(m_fb));
    check("fee_tick_a", 32'(ft_a), 32'(e_fta));
    check("fee_tick_b", 32'(ft_b), 32'(e_ftb));
    check("sat_a", 32'(sat_a), 32'(e_sata));
    check("sat_b", 32'(sat_b), 32'(e_satb));
  endtask

  // One clock: apply inputs, advance the model, then sample 1 unit after the edge.
  task automatic cyc(input bit tog, input bit e, input bit c, input bit mx);
    bit ev;
    int nf;
    en = e; clear = c; max_in = mx;
    if (tog) min_pulse = ~min_pulse;
    ev = (min_pulse != m_q);
    m_q = min_pulse;
    e_tick = ev;
    e_fta = 1'b0;
    e_ftb = 1'b0;
    if (c) begin
      m_min = 0; m_fa = 0; m_fb = 0;
    end else if (!mx && ev && e && m_min < 99) begin
      m_min++;
      if (m_min > 3) begin
        nf = charged(m_fa, 10);   e_fta = (nf != m_fa); m_fa = nf;
        nf = charged(m_fb, 1000); e_ftb = (nf != m_fb); m_fb = nf;
      end
    end
    e_sata = !c && (m_min == 99 || m_fa == 4095);
    e_satb = !c && (m_min == 99 || m_fb == 4095);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clear = 1'b0; max_in = 1'b0; min_pulse = 1'b0;
    m_min = 0; m_fa = 0; m_fb = 0; m_q = 1'b0;
    e_tick = 0; e_fta = 0; e_ftb = 0; e_sata = 0; e_satb = 0;
    @(posedge clk); #1;
    compare_all();
    rst = 1'b0;
  endtask

  task automatic toggles(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      if (gaps) begin
        int g;
        g = int'($urandom_range(2, 0));
        for (int k = 0; k < g; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Minutes 01..04: fee first charged on the 4th toggle
    toggles(4, 1'b1);
    // Carry through 09 -> 10, then back-to-back toggles
    toggles(6, 1'b1);
    toggles(5, 1'b0);

    // en low: toggles ignored, then long idle, then normal count
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    // Same with max_in freeze
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // Run to 99 and beyond: minutes hold, fee unchanged, ticks continue
    toggles(99 - m_min, 1'b0);
    toggles(2, 1'b1);

    // Clear, count to 05 (fee 20), then toggle coincident with clear
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    toggles(5, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized mix of control inputs
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(1, 0)), ($urandom_range(9, 0) != 0),
          ($urandom_range(49, 0) == 0), ($urandom_range(9, 0) == 0));
    end

    // Reset in the middle of counting
    toggles(7, 1'b1);
    do_reset();
    toggles(6, 1'b1);
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(1, 0)), ($urandom_range(7, 0) != 0),
          ($urandom_range(99, 0) == 0), ($urandom_range(15, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
